// File: rtl/instr_encoder_loader_if.sv
// Symbolic instruction stream into the program loader.
// Source drives the beat; loader answers with in_ready.
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  op;
  logic [2:0]  fa;
  logic [2:0]  fb;
  logic [2:0]  fc;
  logic [7:0]  disp;
  logic [15:0] imm;

  modport master (
    output in_valid, in_last, op, fa, fb, fc, disp, imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, op, fa, fb, fc, disp, imm,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instructions to 16-bit words and writes them
// into instruction memory, holding the CPU until the load is done.
module instr_encoder_loader #(
  parameter int ADDR_W   = 8,
  parameter int BASE_ADR = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_W-1:0]   mem_adr,
  output logic [15:0]         mem_dout,
  output logic                mem_we,
  output logic                cpu_hold,
  output logic [ADDR_W:0]     word_cnt,
  output logic                err,
  output logic [7:0]          status
);

  typedef enum logic [2:0] {
    IDLE, LOAD, IMM, DONE, ERR
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CAP =
    (ADDR_W+1)'(DEPTH - BASE_ADR);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADR);
  localparam logic [ADDR_W-1:0] PMAX = '1;

  state_t state;
  state_t nxt;

  logic [ADDR_W-1:0] ptr;
  logic [15:0]       imm_q;
  logic              last_q;

  logic        fire;
  logic        is_ldi;
  logic        ovf;
  logic [ADDR_W:0] free;
  logic [8:0]  operand;
  logic [15:0] enc;

  logic op_rrr, op_cmp, op_rr, op_ldi, op_br, op_jmp;

  assign fire   = bus.in_valid & bus.in_ready;
  assign is_ldi = (bus.op == 4'hA);
  assign free   = CAP - word_cnt;
  assign ovf    = (word_cnt == CAP) ||
                  (is_ldi && free < (ADDR_W+1)'(2));

  assign op_rrr = (bus.op <= 4'h1);
  assign op_cmp = (bus.op == 4'h2);
  assign op_rr  = (bus.op >= 4'h3) && (bus.op <= 4'h9);
  assign op_ldi = is_ldi;
  assign op_br  = (bus.op >= 4'hC) && (bus.op <= 4'hE);
  assign op_jmp = (bus.op == 4'hF);

  // operand field per opcode class; unused bits forced to zero
  always_comb begin
    operand = '0;
    unique case (1'b1)
      op_rrr:  operand = {bus.fa, bus.fb, bus.fc};
      op_cmp:  operand = {3'b000, bus.fb, bus.fc};
      op_rr:   operand = {bus.fa, 3'b000, bus.fc};
      op_ldi:  operand = {bus.fa, 6'b000000};
      op_br:   operand = {1'b0, bus.disp};
      op_jmp:  operand = {6'b000000, bus.fc};
      default: operand = '0;
    endcase
  end

  assign enc = {3'b111, bus.op, operand};

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = LOAD;
      LOAD: begin
        if (fire) begin
          if (ovf)              nxt = ERR;
          else if (is_ldi)      nxt = IMM;
          else if (bus.in_last) nxt = DONE;
        end
      end
      IMM:  nxt = last_q ? DONE : LOAD;
      DONE: if (start) nxt = LOAD;
      ERR:  nxt = ERR;
      default: nxt = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    bus.in_ready = 1'b0;
    status       = 8'h01;
    unique case (state)
      IDLE: status = 8'h01;
      LOAD: begin
        bus.in_ready = 1'b1;
        status       = 8'h02;
      end
      IMM:  status = 8'h04;
      DONE: status = 8'h08;
      ERR:  status = 8'hF0;
      default: status = 8'h01;
    endcase
  end

  // write port, pointer, counters and hold/error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we   <= 1'b0;
      mem_adr  <= BASE;
      mem_dout <= '0;
      ptr      <= BASE;
      word_cnt <= '0;
      imm_q    <= '0;
      last_q   <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      mem_we   <= 1'b0;
      err      <= err | (nxt == ERR);
      cpu_hold <= !((state == DONE) && (nxt == DONE));
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            ptr      <= BASE;
            word_cnt <= '0;
          end
        end
        LOAD: begin
          if (fire && !ovf) begin
            mem_we   <= 1'b1;
            mem_adr  <= ptr;
            mem_dout <= enc;
            word_cnt <= word_cnt + 1'b1;
            if (ptr != PMAX) ptr <= ptr + 1'b1;
            if (is_ldi) begin
              imm_q  <= bus.imm;
              last_q <= bus.in_last;
            end
          end
        end
        IMM: begin
          mem_we   <= 1'b1;
          mem_adr  <= ptr;
          mem_dout <= imm_q;
          word_cnt <= word_cnt + 1'b1;
          if (ptr != PMAX) ptr <= ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding, LDI,
// completion/hold, restart, overflow and reset-in-IMM.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic start = 1'b0;

  logic        v_valid = 1'b0;
  logic        v_last  = 1'b0;
  logic [3:0]  v_op    = '0;
  logic [2:0]  v_fa    = '0;
  logic [2:0]  v_fb    = '0;
  logic [2:0]  v_fc    = '0;
  logic [7:0]  v_disp  = '0;
  logic [15:0] v_imm   = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder_loader_if ia ();
  instr_encoder_loader_if ib ();

  assign ia.in_valid = v_valid;
  assign ia.in_last  = v_last;
  assign ia.op       = v_op;
  assign ia.fa       = v_fa;
  assign ia.fb       = v_fb;
  assign ia.fc       = v_fc;
  assign ia.disp     = v_disp;
  assign ia.imm      = v_imm;
  assign ib.in_valid = v_valid;
  assign ib.in_last  = v_last;
  assign ib.op       = v_op;
  assign ib.fa       = v_fa;
  assign ib.fb       = v_fb;
  assign ib.fc       = v_fc;
  assign ib.disp     = v_disp;
  assign ib.imm      = v_imm;

  logic [7:0]  a_adr;
  logic [15:0] a_dout;
  logic        a_we, a_hold, a_err;
  logic [8:0]  a_cnt;
  logic [7:0]  a_st;

  logic [1:0]  b_adr;
  logic [15:0] b_dout;
  logic        b_we, b_hold, b_err;
  logic [2:0]  b_cnt;
  logic [7:0]  b_st;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADR(0)) dut_a (
    .clk(clk), .reset(rst_a), .start(start), .bus(ia),
    .mem_adr(a_adr), .mem_dout(a_dout), .mem_we(a_we),
    .cpu_hold(a_hold), .word_cnt(a_cnt), .err(a_err),
    .status(a_st)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADR(0)) dut_b (
    .clk(clk), .reset(rst_b), .start(start), .bus(ib),
    .mem_adr(b_adr), .mem_dout(b_dout), .mem_we(b_we),
    .cpu_hold(b_hold), .word_cnt(b_cnt), .err(b_err),
    .status(b_st)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [3:0] op,
                      input logic [2:0] fa, fb, fc,
                      input logic [7:0] disp,
                      input logic [15:0] imm,
                      input logic last);
    v_op = op; v_fa = fa; v_fb = fb; v_fc = fc;
    v_disp = disp; v_imm = imm; v_last = last;
    v_valid = 1'b1;
    tick();
    v_valid = 1'b0;
    v_last  = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst_a = 1'b0;

    check("rst_status", 32'(a_st), 32'h01);
    check("rst_we", 32'(a_we), 32'h0);
    check("rst_adr", 32'(a_adr), 32'h0);
    check("rst_dout", 32'(a_dout), 32'h0);
    check("rst_hold", 32'(a_hold), 32'h1);
    check("rst_cnt", 32'(a_cnt), 32'h0);
    check("rst_err", 32'(a_err), 32'h0);
    check("rst_ready", 32'(ia.in_ready), 32'h0);

    pulse_start();
    check("load_status", 32'(a_st), 32'h02);
    check("load_ready", 32'(ia.in_ready), 32'h1);

    beat(4'h0, 3'd3, 3'd1, 3'd2, 8'h00, 16'h0, 1'b0);
    check("add_we", 32'(a_we), 32'h1);
    check("add_adr", 32'(a_adr), 32'h0);
    check("add_dout", 32'(a_dout), 32'hE0CA);
    check("add_cnt", 32'(a_cnt), 32'h1);
    check("add_ready", 32'(ia.in_ready), 32'h1);

    beat(4'hA, 3'd5, 3'd0, 3'd0, 8'h00, 16'h1234, 1'b0);
    check("ldi_we", 32'(a_we), 32'h1);
    check("ldi_adr", 32'(a_adr), 32'h1);
    check("ldi_dout", 32'(a_dout), 32'hF540);
    check("ldi_ready", 32'(ia.in_ready), 32'h0);
    check("ldi_status", 32'(a_st), 32'h04);
    tick();
    check("imm_we", 32'(a_we), 32'h1);
    check("imm_adr", 32'(a_adr), 32'h2);
    check("imm_dout", 32'(a_dout), 32'h1234);
    check("imm_ready", 32'(ia.in_ready), 32'h1);
    check("imm_cnt", 32'(a_cnt), 32'h3);

    beat(4'hD, 3'd7, 3'd7, 3'd7, 8'hFC, 16'h0, 1'b0);
    check("jne_adr", 32'(a_adr), 32'h3);
    check("jne_dout", 32'(a_dout), 32'hFAFC);

    tick();
    check("gap_we", 32'(a_we), 32'h0);

    beat(4'h2, 3'd7, 3'd2, 3'd3, 8'h00, 16'h0, 1'b0);
    check("cmp_adr", 32'(a_adr), 32'h4);
    check("cmp_dout", 32'(a_dout), 32'hE413);

    beat(4'hB, 3'd7, 3'd7, 3'd7, 8'hFF, 16'h0, 1'b1);
    check("halt_we", 32'(a_we), 32'h1);
    check("halt_adr", 32'(a_adr), 32'h5);
    check("halt_dout", 32'(a_dout), 32'hF600);
    check("halt_status", 32'(a_st), 32'h08);
    check("halt_hold0", 32'(a_hold), 32'h1);
    check("halt_cnt", 32'(a_cnt), 32'h6);
    tick();
    check("done_hold", 32'(a_hold), 32'h0);
    check("done_we", 32'(a_we), 32'h0);
    check("done_ready", 32'(ia.in_ready), 32'h0);

    pulse_start();
    check("rel_hold", 32'(a_hold), 32'h1);
    check("rel_status", 32'(a_st), 32'h02);
    check("rel_cnt", 32'(a_cnt), 32'h0);
    beat(4'h3, 3'd1, 3'd7, 3'd2, 8'h00, 16'h0, 1'b0);
    check("mov_adr", 32'(a_adr), 32'h0);
    check("mov_dout", 32'(a_dout), 32'hE642);

    beat(4'hA, 3'd2, 3'd0, 3'd0, 8'h00, 16'hBEEF, 1'b0);
    check("ldi2_dout", 32'(a_dout), 32'hF480);
    check("ldi2_status", 32'(a_st), 32'h04);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("rimm_we", 32'(a_we), 32'h0);
    check("rimm_hold", 32'(a_hold), 32'h1);
    check("rimm_status", 32'(a_st), 32'h01);
    check("rimm_cnt", 32'(a_cnt), 32'h0);
    check("rimm_dout", 32'(a_dout), 32'h0);

    rst_a = 1'b1;
    rst_b = 1'b0;
    tick();
    pulse_start();
    check("b_status", 32'(b_st), 32'h02);
    beat(4'h0, 3'd1, 3'd1, 3'd1, 8'h00, 16'h0, 1'b0);
    beat(4'h1, 3'd2, 3'd2, 3'd2, 8'h00, 16'h0, 1'b0);
    beat(4'h6, 3'd3, 3'd0, 3'd3, 8'h00, 16'h0, 1'b0);
    check("b_cnt3", 32'(b_cnt), 32'h3);
    check("b_adr2", 32'(b_adr), 32'h2);
    beat(4'hA, 3'd1, 3'd0, 3'd0, 8'h00, 16'hAAAA, 1'b0);
    check("ovf_we", 32'(b_we), 32'h0);
    check("ovf_err", 32'(b_err), 32'h1);
    check("ovf_status", 32'(b_st), 32'hF0);
    check("ovf_cnt", 32'(b_cnt), 32'h3);
    check("ovf_hold", 32'(b_hold), 32'h1);
    check("ovf_ready", 32'(ib.in_ready), 32'h0);
    tick();
    check("ovf_we2", 32'(b_we), 32'h0);
    pulse_start();
    check("err_start", 32'(b_st), 32'hF0);
    check("err_sticky", 32'(b_err), 32'h1);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check("err_clr", 32'(b_err), 32'h0);
    check("err_idle", 32'(b_st), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Writer-side counterpart to the control unit's fetch/decode path. It accepts symbolic instructions (opcode index plus register fields, displacement and immediate) over a valid/ready handshake.
- It encodes each instruction into the 16-bit RISC format: IR[15:9] = 7'h70 + opcode index.
- It writes the encoded words sequentially into instruction memory.
- It holds the CPU in reset (cpu_hold) until the program load completes.

Parameters:
- ADDR_W, 8, memory address width; depth = 2^ADDR_W words.
- BASE_ADR, 0, first memory address written.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a (re)load at BASE_ADR
- in_valid  in  1  instruction beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_last  in  1  beat is the final instruction of the program
- op  in  4  opcode index: 0 ADD, 1 SUB, 2 CMP, 3 MOV, 4 SHL, 5 SHR, 6 INC, 7 DEC, 8 LD, 9 STO, A LDI, B HALT, C JE, D JNE, E JC, F JMP
- fa  in  3  field placed in IR[8:6]
- fb  in  3  field placed in IR[5:3]
- fc  in  3  field placed in IR[2:0]
- disp  in  8  branch displacement, placed in IR[7:0]
- imm  in  16  LDI immediate (second word)
- mem_adr  out  ADDR_W  write address
- mem_dout  out  16  write data
- mem_we  out  1  memory write strobe
- cpu_hold  out  1  high keeps the CPU in reset
- word_cnt  out  ADDR_W+1  words written since start
- err  out  1  overflow error, sticky
- status  out  8  LED state code

Behaviour:
- Reset values: state IDLE, mem_we 0, mem_adr BASE_ADR, mem_dout 0, cpu_hold 1, word_cnt 0, err 0, in_ready 0, status 8'h01.
- Encoding, with unused fields forced to 0:
  - ADD/SUB: {fa,fb,fc}.
  - CMP: {000,fb,fc}.
  - MOV/SHL/SHR/INC/DEC/LD/STO: {fa,000,fc}.
  - LDI: {fa,000000}.
  - HALT: 0.
  - JE/JNE/JC: {0,disp}.
  - JMP: {000000,fc}.
- IDLE:
  - in_ready 0, cpu_hold 1.
  - start moves to LOAD; the write pointer is set to BASE_ADR and word_cnt is cleared.
- LOAD:
  - in_ready 1.
  - On transfer (in_valid & in_ready), the next edge registers mem_we=1, mem_adr=ptr and mem_dout=encoded word, then increments ptr and word_cnt. This is one-cycle latency, with no combinational path from inputs to memory outputs.
  - On a cycle with no transfer, mem_we is registered as 0.
  - For an LDI transfer, imm is latched and the state goes to IMM.
  - For any other opcode with in_last set, the state goes to DONE; otherwise it stays in LOAD.
- IMM:
  - in_ready 0.
  - The next edge writes the latched imm at ptr, increments ptr and word_cnt, and goes to DONE if in_last was latched with the LDI, otherwise back to LOAD.
- DONE:
  - in_ready 0; cpu_hold drops to 0 on the edge after the final write is registered.
  - start returns to LOAD with cpu_hold 1, ptr BASE_ADR and word_cnt 0.
- Overflow:
  - A transfer when word_cnt equals 2^ADDR_W − BASE_ADR, or an LDI transfer with fewer than 2 free words, performs no write at all (no partial LDI).
  - The state goes to ERR: err=1, cpu_hold 1, in_ready 0.
  - ERR is exited only by reset; start is ignored.
- The address never wraps past 2^ADDR_W−1.
- start is ignored in LOAD and IMM.
- reset in any state, including mid-LDI, returns to the reset values on the next edge. The partial program stays in memory, but cpu_hold stays 1.
- status codes: IDLE 8'h01, LOAD 8'h02, IMM 8'h04, DONE 8'h08, ERR 8'hF0.

Test Plan:
- ADD fa=3, fb=1, fc=2, in_last=0 → mem_we pulse, adr 0, dout 16'hE0CA; word_cnt=1; in_ready stays 1.
- LDI fa=5, imm=16'h1234 → writes 16'hF540 at adr n and 16'h1234 at adr n+1 on consecutive cycles; in_ready low for exactly one cycle.
- JNE disp=8'hFC with fa/fb/fc=7 → dout 16'hFAFC; CMP fa=7, fb=2, fc=3 → 16'hE413 (fa masked).
- HALT with in_last=1 → dout 16'hF600; cpu_hold falls one cycle later; status 8'h08. A subsequent start → cpu_hold 1, the next write goes to BASE_ADR.
- ADDR_W=2, BASE_ADR=0:
  - Three singles then an LDI → no write for the LDI, err=1, status 8'hF0, word_cnt=3.
  - start ignored; reset clears err.
- Reset asserted in IMM → no imm write, mem_we 0, cpu_hold 1, state IDLE, word_cnt 0.
